// File: rtl/hex_display_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_pkg : 7-segment constants and nibble decode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segments, bit0=a .. bit6=g, indexed by nibble value.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_tick_divider.sv
// ---------------------------------------------------------------------------
// clock_tick_divider : enable-gated divider, registered one-cycle tick. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clock_tick_divider #(
  parameter int DIV_MAX = 12_000_000 - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV_MAX);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (div_cnt == TERM) begin
          div_cnt <= '0;
          tick    <= 1'b1;
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_counter_display.sv
// ---------------------------------------------------------------------------
// hex_counter_display : multi-digit hex counter with 7-segment decode. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_counter_display #(
  parameter int                      NUM_DIGITS    = 4,
  parameter int                      DIV_MAX       = 12_000_000 - 1,
  parameter logic [4*NUM_DIGITS-1:0] MAX_VALUE     = '1,
  parameter bit                      BLANK_LEADING = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      step,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  output logic [4*NUM_DIGITS-1:0]   count,
  output logic [7*NUM_DIGITS-1:0]   hex,
  output logic                      tick,
  output logic                      wrap
);

  import hex_display_pkg::*;

  localparam int W = 4 * NUM_DIGITS;

  logic           step_prev;
  logic           step_pulse;
  logic           advance;
  logic [W-1:0]   load_sat;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [7*NUM_DIGITS-1:0] hex_rst;

  clock_tick_divider #(
    .DIV_MAX(DIV_MAX)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(load),
    .tick (tick)
  );

  // step edge is registered so it lines up with the registered tick.
  assign advance  = tick | step_pulse;
  assign load_sat = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev  <= 1'b1;
      step_pulse <= 1'b0;
      count      <= '0;
      wrap       <= 1'b0;
    end else begin
      step_prev  <= step;
      step_pulse <= step & ~step_prev;
      wrap       <= 1'b0;
      if (load) begin
        count <= load_sat;
      end else if (advance) begin
        if (!dir) begin
          if (count == MAX_VALUE) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + W'(1);
          end
        end else begin
          if (count == '0) begin
            count <= MAX_VALUE;
            wrap  <= 1'b1;
          end else begin
            count <= count - W'(1);
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic upper_zero;
    assign upper_zero = ((count >> (4 * i)) == '0);
    assign hex_next[7*i +: 7] = (BLANK_LEADING && (i > 0) && upper_zero)
                                ? SEG_BLANK : hex_to_seg(count[4*i +: 4]);
    assign hex_rst[7*i +: 7]  = (BLANK_LEADING && (i > 0))
                                ? SEG_BLANK : hex_to_seg(4'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex <= hex_rst;
    end else begin
      hex <= hex_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_counter_display.sv
// ---------------------------------------------------------------------------
// tb_hex_counter_display : vector table, directed corners, random vs model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex_counter_display;

  localparam int ND = 2;
  localparam int DM = 3;
  localparam logic [7:0] MV = 8'h1F;
  localparam int MVI = 31;
  localparam logic [6:0] BLK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst, en, dir, step, load;
  logic [7:0]  load_value;
  logic [7:0]  count;
  logic [13:0] hex;
  logic        tick, wrap;

  int checks = 0;
  int errors = 0;
  bit tick_seen;

  hex_counter_display #(
    .NUM_DIGITS   (ND),
    .DIV_MAX      (DM),
    .MAX_VALUE    (MV),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .step      (step),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .hex       (hex),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_div, m_count;
  bit          m_tick, m_prev, m_pulse, m_wrap;
  logic [13:0] m_hex;

  localparam logic [6:0] SEGS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [13:0] disp(int v);
    logic [13:0] r;
    int hi = 0;
    for (int i = 0; i < ND; i++) if (((v >> (4 * i)) & 15) != 0) hi = i;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = (i > hi) ? BLK : SEGS[(v >> (4 * i)) & 15];
    return r;
  endfunction

  task automatic model_step();
    bit adv;
    int nxt;
    logic [13:0] nh;
    if (rst) begin
      m_div = 0; m_tick = 0; m_prev = 1; m_pulse = 0;
      m_count = 0; m_wrap = 0; m_hex = disp(0);
    end else begin
      nh      = disp(m_count);
      adv     = m_tick || m_pulse;
      m_pulse = step && !m_prev;
      m_prev  = step;
      if (load) begin
        m_count = (int'(load_value) > MVI) ? MVI : int'(load_value);
        m_wrap = 0; m_div = 0; m_tick = 0;
      end else begin
        m_tick = en && (m_div == DM);
        if (en) m_div = (m_div + 1) % (DM + 1);
        if (adv) begin
          nxt    = dir ? (m_count + MVI) % (MVI + 1) : (m_count + 1) % (MVI + 1);
          m_wrap = dir ? (nxt > m_count) : (nxt < m_count);
          m_count = nxt;
        end else begin
          m_wrap = 0;
        end
      end
      m_hex = nh;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (tick === 1'b1) tick_seen = 1;
    chk("model_count", 32'(count), 32'(m_count));
    chk("model_tick",  32'(tick),  32'(m_tick));
    chk("model_wrap",  32'(wrap),  32'(m_wrap));
    chk("model_hex",   32'(hex),   32'(m_hex));
  endtask

  typedef struct {
    logic [7:0]  lv;
    logic [7:0]  c;
    logic [13:0] h;
  } vec_t;
  vec_t vecs[16];

  initial begin
    logic [7:0] start;
    bit ok;
    vecs = '{
      '{8'h00, 8'h00, {BLK,        7'b1000000}},
      '{8'h11, 8'h11, {7'b1111001, 7'b1111001}},
      '{8'h02, 8'h02, {BLK,        7'b0100100}},
      '{8'h13, 8'h13, {7'b1111001, 7'b0110000}},
      '{8'h04, 8'h04, {BLK,        7'b0011001}},
      '{8'h05, 8'h05, {BLK,        7'b0010010}},
      '{8'h16, 8'h16, {7'b1111001, 7'b0000010}},
      '{8'h17, 8'h17, {7'b1111001, 7'b1111000}},
      '{8'h08, 8'h08, {BLK,        7'b0000000}},
      '{8'h19, 8'h19, {7'b1111001, 7'b0010000}},
      '{8'h1A, 8'h1A, {7'b1111001, 7'b0001000}},
      '{8'h0B, 8'h0B, {BLK,        7'b0000011}},
      '{8'h1C, 8'h1C, {7'b1111001, 7'b1000110}},
      '{8'h0D, 8'h0D, {BLK,        7'b0100001}},
      '{8'h1E, 8'h1E, {7'b1111001, 7'b0000110}},
      '{8'hA5, 8'h1F, {7'b1111001, 7'b0001110}}
    };

    rst = 1; en = 0; dir = 0; step = 0; load = 0; load_value = 8'h00;
    tick_seen = 0;
    @(negedge clk);
    cycle();
    chk("reset_count", 32'(count), 32'h00);
    chk("reset_hex", 32'(hex), 32'({BLK, 7'b1000000}));
    chk("reset_tick_wrap", 32'({tick, wrap}), 32'h0);

    // Count up from reset: tick on 4th enabled edge, count one edge later.
    rst = 0; en = 1;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk("tick_early", 32'(tick), 32'h0);
    end
    cycle();
    chk("tick_first", 32'(tick), 32'h1);
    cycle();
    chk("count_first", 32'(count), 32'h01);
    cycle();
    chk("hex_first", 32'(hex), 32'({BLK, 7'b1111001}));

    // Run up to 1F, then wrap to 00.
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin cycle(); ok = (count == 8'h1F); end
    chk("reach_1F", 32'(ok), 32'h1);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin cycle(); ok = (count != 8'h1F); end
    chk("wrap_up_count", 32'(count), 32'h00);
    chk("wrap_up_pulse", 32'(wrap), 32'h1);
    cycle();
    chk("wrap_up_one_cycle", 32'(wrap), 32'h0);
    chk("wrap_up_hex", 32'(hex), 32'({BLK, 7'b1000000}));

    // Count down from 00 wraps to 1F.
    dir = 1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin cycle(); ok = (count != 8'h00); end
    chk("wrap_dn_count", 32'(count), 32'h1F);
    chk("wrap_dn_pulse", 32'(wrap), 32'h1);
    cycle();
    chk("wrap_dn_hex", 32'(hex), 32'({7'b1111001, 7'b0001110}));

    // Manual steps with divider frozen.
    en = 0; dir = 0; tick_seen = 0;
    cycle();
    start = count;
    for (int p = 0; p < 2; p++) begin
      step = 1; repeat (3) cycle();
      step = 0; repeat (3) cycle();
    end
    chk("step_two_adv", 32'(count), 32'((start + 8'd2) & 8'h1F));
    chk("step_no_tick", 32'(tick_seen), 32'h0);

    // Load coincident with a tick: saturates, no advance.
    en = 1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin cycle(); ok = (tick == 1'b1); end
    chk("tick_before_load", 32'(ok), 32'h1);
    load = 1; load_value = 8'hA5;
    cycle();
    chk("load_sat", 32'(count), 32'h1F);
    chk("load_no_wrap", 32'(wrap), 32'h0);
    load = 0;
    cycle();
    chk("load_no_extra_adv", 32'(count), 32'h1F);
    load = 1; load_value = 8'h10;
    cycle();
    chk("load_10", 32'(count), 32'h10);
    load = 0;

    // Decode table: load each value with the divider off.
    en = 0;
    foreach (vecs[v]) begin
      load = 1; load_value = vecs[v].lv;
      cycle();
      load = 0;
      cycle();
      chk("vec_count", 32'(count), 32'(vecs[v].c));
      chk("vec_hex", 32'(hex), 32'(vecs[v].h));
    end

    // Step held high through reset must not advance.
    step = 1; rst = 1;
    cycle();
    rst = 0;
    repeat (3) cycle();
    chk("step_thru_rst", 32'(count), 32'h00);
    step = 0;

    // Reset mid-divide loses divider progress.
    load = 1; load_value = 8'h0C;
    cycle();
    load = 0; en = 1;
    repeat (2) cycle();
    chk("pre_rst_count", 32'(count), 32'h0C);
    rst = 1;
    cycle();
    chk("mid_rst_count", 32'(count), 32'h00);
    rst = 0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("tick_after_rst", 32'(tick), 32'(k == 4));
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 3) == 0) step = ~step;
      load = ($urandom_range(0, 39) == 0);
      load_value = 8'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_counter_display.md
# hex_counter_display

Parametrised multi-digit hex counter with built-in tick divider and registered 7-segment decode. It is the successor to the single-digit 0–F demo counter. It adds a configurable digit count, modulus, rate, up/down counting, synchronous load, a debounced-edge manual step, leading-zero blanking and a wrap pulse. It sits between board inputs (KEY/SW) and the HEX outputs, and is the standard display driver for visible counters and register readouts.

## Interface
- NUM_DIGITS, 4, number of hex digits (1–8); count width W = 4*NUM_DIGITS
- DIV_MAX, 12_000_000-1, divider terminal value; tick every DIV_MAX+1 enabled cycles (2 Hz at 24 MHz)
- MAX_VALUE, 16**NUM_DIGITS-1, count wraps MAX_VALUE↔0
- BLANK_LEADING, 0, 1 = blank leading zero digits
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-high; one clock
- en  in  1  divider run enable; divider holds when low
- dir  in  1  0 = count up, 1 = count down
- step  in  1  manual advance; rising edge (0→1 between consecutive cycles) = one advance
- load  in  1  synchronous load strobe
- load_value  in  W  value loaded; values > MAX_VALUE saturate to MAX_VALUE
- count  out  W  current count, registered
- hex  out  7*NUM_DIGITS  digit i in bits [7i+6:7i], active-low, bit0=a … bit6=g
- tick  out  1  one-cycle divider pulse
- wrap  out  1  one-cycle pulse on wrap-around

## Operation
- Priority per cycle: rst > load > advance.
- Divider: increments while en=1. At DIV_MAX with en=1 it asserts tick and returns to 0. Holds while en=0. Cleared by rst and by load.
- Advance event = tick OR step rising edge. Both in the same cycle produce one advance only.
- Up: count+1. At MAX_VALUE count goes to 0 and wrap=1.
- Down: count−1. At 0 count goes to MAX_VALUE and wrap=1.
- load: count ← min(load_value, MAX_VALUE). No wrap. Any advance in the same cycle is discarded.
- Step edge register resets to 1, so a step held high through reset does not advance.
- Decode per nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- BLANK_LEADING=1: digits above the highest nonzero nibble output 1111111. Digit 0 is never blanked.

## Timing
- Reset values: count=0, divider=0, tick=0, wrap=0, hex = digit 0 showing "0" (1000000). Higher digits show 1000000, or 1111111 when BLANK_LEADING=1.
- tick is registered and asserts in the cycle after the divider reaches DIV_MAX.
- count updates on the clock edge after an advance event or load is sampled. wrap is asserted for exactly the cycle in which the new count first appears.
- hex is registered from count: 1 cycle behind count, 2 cycles after the event.
- Step: rising edge sampled at edge k (step=1, previous=0) → count changes after edge k+1.
- rst asserted mid-count clears everything on the next edge. Partial divider progress is lost.
- dir change takes effect on the next advance. No glitch on the current count.

## Structure
- Package hex_display_pkg: 16-entry segment constant table, SEG_BLANK = 7'b1111111, and function hex_to_seg(nibble).
- Sub-module clock_tick_divider (params DIV_MAX; ports clk, rst, en, clear, tick). The counter/decode logic stays in hex_counter_display.
- No other hierarchy. Decode is generated per digit.

## Test plan
Bench parameters: NUM_DIGITS=2, DIV_MAX=3, MAX_VALUE=8'h1F, BLANK_LEADING=1.
- Reset then en=1, dir=0 → tick every 4 cycles; count 00,01,02…; hex[6:0]=1111001 two cycles after first advance; hex[13:7]=1111111.
- Count up to 1F then one tick → count=00, wrap=1 for one cycle; hex[13:7] returns to 1111111.
- dir=1 from 00, one tick → count=1F, wrap=1; hex = 1111001 / 0001110 one cycle later.
- en=0, step pulsed high 3 cycles then low, twice → exactly 2 advances; divider frozen (tick never asserts).
- load=1 with load_value=8'hA5 coincident with a tick → count=1F (saturated), wrap=0, no extra advance; load_value=8'h10 → count=10.
- step held high across rst deassertion → no advance. rst asserted mid-divide with count=0x0C → count=00, divider restarts, next tick 4 cycles after release.
